// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer (F_PC + F/D register) for a variable-latency imem; optional FETCH_ADDR_CHK_EN adds the D_exc_adel fetch-address check.
// Latency: one instruction per cycle into D when imem acks every cycle; D_PC trails F_PC by one cycle.
// Backpressure: stall freezes F and D; a word acked under stall is parked in hold_buf until stall drops.
module fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] PC_MIN   = 32'h0000_3000,
  parameter logic [31:0] PC_MAX   = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        D_valid,
`ifdef FETCH_ADDR_CHK_EN
  output logic        D_exc_adel,
`endif
  output logic        fetch_busy
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  logic        pend_v;
  logic [31:0] pend_tgt;
  logic [31:0] hold_buf;

  logic        addr_err;
  logic        ack_ok;
  logic        fetch_rdy;
  logic [31:0] fetch_word;
  logic        redirect;
  logic        transfer;
  logic [31:0] xfer_word;
  logic [31:0] next_pc;

`ifdef FETCH_ADDR_CHK_EN
  logic hold_exc;
  logic xfer_exc;

  assign addr_err = (F_PC[1:0] != 2'b00) || (F_PC < PC_MIN) || (F_PC > PC_MAX);
  assign xfer_exc = (state == HOLD) ? hold_exc : addr_err;
`else
  logic unused_cfg;

  assign addr_err   = 1'b0;
  assign unused_cfg = ^{PC_MIN, PC_MAX};
`endif

  assign imem_req   = !reset && (state == FETCH) && !addr_err;
  assign imem_addr  = F_PC;
  assign fetch_busy = (state == FETCH) && !imem_ack;

  // A bad fetch address completes locally, as if imem had returned a zero word.
  assign ack_ok     = imem_req && imem_ack;
  assign fetch_rdy  = ack_ok || ((state == FETCH) && addr_err);
  assign fetch_word = addr_err ? 32'h0 : imem_rdata;

  assign redirect  = npc_sel && !stall;
  assign transfer  = !stall && ((state == HOLD) || fetch_rdy);
  assign xfer_word = (state == HOLD) ? hold_buf : fetch_word;

  assign next_pc = redirect ? npc_target :
                   pend_v   ? pend_tgt   :
                              F_PC + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      F_PC     <= PC_RESET;
      D_PC     <= 32'h0;
      D_instr  <= 32'h0;
      D_valid  <= 1'b0;
      pend_v   <= 1'b0;
      pend_tgt <= 32'h0;
      hold_buf <= 32'h0;
`ifdef FETCH_ADDR_CHK_EN
      hold_exc   <= 1'b0;
      D_exc_adel <= 1'b0;
`endif
    end else begin
      if (transfer) begin
        D_instr <= xfer_word;
        D_PC    <= F_PC;
        D_valid <= 1'b1;
        F_PC    <= next_pc;
        state   <= FETCH;
`ifdef FETCH_ADDR_CHK_EN
        D_exc_adel <= xfer_exc;
`endif
      end else if (state == FETCH) begin
        if (fetch_rdy) begin
          // stall is high here: park the word so the request is not reissued
          hold_buf <= fetch_word;
          state    <= HOLD;
`ifdef FETCH_ADDR_CHK_EN
          hold_exc <= addr_err;
`endif
        end else if (!stall) begin
          D_valid <= 1'b0;
        end
      end

      // The delay-slot fetch is still in flight; remember where to go after it lands.
      if (transfer) begin
        pend_v <= 1'b0;
      end else if (redirect) begin
        pend_v   <= 1'b1;
        pend_tgt <= npc_target;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized and directed bench for fetch_ctrl against a queue-based model of the fetch stream.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        npc_sel;
  logic [31:0] npc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic        D_valid;
  logic        fetch_busy;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Model: the word fetched but not yet accepted by D, and any redirect still owed.
  logic [31:0] m_fpc, m_dpc, m_dinstr;
  logic        m_dvalid;
  logic [31:0] m_parked[$];
  logic [31:0] m_redir[$];

  fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc_sel    (npc_sel),
    .npc_target (npc_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .F_PC       (F_PC),
    .D_PC       (D_PC),
    .D_instr    (D_instr),
    .D_valid    (D_valid),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fpc    = 32'h0000_3000;
    m_dpc    = 32'h0;
    m_dinstr = 32'h0;
    m_dvalid = 1'b0;
    m_parked.delete();
    m_redir.delete();
  endtask

  task automatic model_step(input bit a, input bit st, input bit sel,
                            input logic [31:0] tgt, input logic [31:0] rd);
    bit          have;
    logic [31:0] word;
    have = (m_parked.size() != 0) || a;
    word = (m_parked.size() != 0) ? m_parked[0] : rd;
    if (!st && have) begin
      m_dpc    = m_fpc;
      m_dinstr = word;
      m_dvalid = 1'b1;
      if (sel)                      m_fpc = tgt;
      else if (m_redir.size() != 0) m_fpc = m_redir[0];
      else                          m_fpc = m_fpc + 32'd4;
      m_parked.delete();
      m_redir.delete();
    end else if (st && have) begin
      if (m_parked.size() == 0) m_parked.push_back(rd);
    end else if (!st) begin
      m_dvalid = 1'b0;
      if (sel) begin
        m_redir.delete();
        m_redir.push_back(tgt);
      end
    end
  endtask

  task automatic check_regs();
    check("F_PC", F_PC, m_fpc);
    check("D_PC", D_PC, m_dpc);
    check("D_instr", D_instr, m_dinstr);
    check("D_valid", 32'(D_valid), 32'(m_dvalid));
  endtask

  // Entered and left on a falling edge.
  task automatic cycle(input bit a, input bit st, input bit sel,
                       input logic [31:0] tgt, input logic [31:0] rd);
    imem_ack   = a;
    stall      = st;
    npc_sel    = sel;
    npc_target = tgt;
    imem_rdata = rd;
    #1;
    check("imem_req", 32'(imem_req), 32'(m_parked.size() == 0));
    check("imem_addr", imem_addr, m_fpc);
    check("fetch_busy", 32'(fetch_busy), 32'((m_parked.size() == 0) && !a));
    @(posedge clk);
    model_step(a, st, sel, tgt, rd);
    @(negedge clk);
    check_regs();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_F_PC"}, F_PC, 32'h0000_3000);
    check({tag, "_D_PC"}, D_PC, 32'h0);
    check({tag, "_D_instr"}, D_instr, 32'h0);
    check({tag, "_D_valid"}, 32'(D_valid), 32'h0);
    check({tag, "_imem_req"}, 32'(imem_req), 32'h0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    imem_ack = 1'b1;
    #1;
    check_reset_vals("rst");
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    imem_ack = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc_sel = 1'b0; npc_target = 32'h0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    model_reset();
    #2;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b0;

    // Streaming fetch
    cycle(1, 0, 0, 0, 32'h1111_0000);
    check("t1_F0", F_PC, 32'h3004);
    check("t1_D0", D_PC, 32'h3000);
    check("t1_V0", 32'(D_valid), 32'h1);
    cycle(1, 0, 0, 0, 32'h1111_0004);
    check("t1_F1", F_PC, 32'h3008);
    cycle(1, 0, 0, 0, 32'h1111_0008);
    check("t1_F2", F_PC, 32'h300C);

    // Three-cycle ack latency, then stall on the ack
    do_reset();
    cycle(0, 0, 0, 0, 0);
    check("t2_bubble", 32'(D_valid), 32'h0);
    cycle(0, 0, 0, 0, 0);
    check("t2_addr", imem_addr, 32'h3000);
    cycle(1, 0, 0, 0, 32'h2222_0000);
    check("t2_D", D_PC, 32'h3000);
    cycle(1, 1, 0, 0, 32'h8C01_0000);
    check("t5_req_hold", 32'(imem_req), 32'h0);
    check("t5_D_held", D_PC, 32'h3000);
    cycle(0, 0, 0, 0, 32'h0);
    check("t5_instr", D_instr, 32'h8C01_0000);
    check("t5_F", F_PC, 32'h3008);

    // Branch with immediate delay-slot ack
    do_reset();
    cycle(1, 0, 0, 0, 32'h3333_0000);
    cycle(1, 0, 0, 0, 32'h3333_0004);
    cycle(1, 0, 1, 32'h3100, 32'h3333_0008);
    check("t3_slot", D_PC, 32'h3008);
    check("t3_F", F_PC, 32'h3100);
    cycle(1, 0, 0, 0, 32'h3333_0100);
    check("t3_tgt", D_PC, 32'h3100);

    // Branch with a delayed delay-slot ack
    do_reset();
    cycle(1, 0, 0, 0, 32'h4444_0000);
    cycle(1, 0, 0, 0, 32'h4444_0004);
    cycle(0, 0, 1, 32'h3100, 0);
    cycle(0, 0, 0, 0, 0);
    check("t4_F_wait", F_PC, 32'h3008);
    cycle(1, 0, 0, 0, 32'h4444_0008);
    check("t4_slot", D_PC, 32'h3008);
    check("t4_F", F_PC, 32'h3100);
    cycle(1, 0, 0, 0, 32'h4444_0100);
    check("t4_pend_clr", F_PC, 32'h3104);

    // Reset in the middle of an outstanding fetch
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 32'h5555_0000 + 32'(i));
    cycle(0, 0, 0, 0, 0);
    check("t6_F_pre", F_PC, 32'h3010);
    #2;
    reset    = 1'b1;
    imem_ack = 1'b1;
    #1;
    check_reset_vals("t6_async");
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("t6_stray");
    reset    = 1'b0;
    imem_ack = 1'b0;
    model_reset();
    cycle(1, 0, 0, 0, 32'h6666_0000);
    check("t6_restart", D_PC, 32'h3000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 99) < 15), ($urandom & 32'hFFFF_FFFC), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the IF stage of the five-stage MIPS pipeline.
- Owns the F-stage PC register and the F/D pipeline register.
- Issues requests to a variable-latency instruction memory, absorbs stalls from the hazard unit, and applies branch/jump redirects from D after the delay slot.
- Replaces the free-running PC register and IF/ID register pair; the combinational next-PC logic in D keeps computing redirect targets.

Parameters:
- PC_RESET, 32'h0000_3000, F_PC value after reset.
- PC_MIN, 32'h0000_3000, lowest legal fetch address (used only with the optional feature).
- PC_MAX, 32'h0000_6FFC, highest legal fetch address (used only with the optional feature).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit freeze of F and D.
- npc_sel  input  1  D-stage redirect taken (branch taken, jal, jr); sampled only when stall=0.
- npc_target  input  32  redirect target, valid with npc_sel.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals F_PC.
- imem_ack  input  1  read data valid; ignored unless imem_req=1.
- imem_rdata  input  32  instruction word, valid with imem_ack.
- F_PC  output  32  current fetch PC.
- D_PC  output  32  PC of the instruction in D.
- D_instr  output  32  instruction in D.
- D_valid  output  1  0 means D holds a bubble (treat as nop).
- fetch_busy  output  1  1 when state=FETCH and imem_ack=0.

Behaviour:
- Reset values (applied asynchronously): F_PC=PC_RESET, D_PC=0, D_instr=0, D_valid=0, state=FETCH, pend_v=0, pend_tgt=0, hold_buf=0. imem_req is forced to 0 while reset=1.
- FSM states: FETCH, HOLD.
- FETCH: imem_req=1.
  - imem_ack=1 and stall=0 ("transfer"): D_instr<=imem_rdata, D_PC<=F_PC, D_valid<=1, F_PC<=next_pc. Stay in FETCH.
  - imem_ack=1 and stall=1: hold_buf<=imem_rdata, go to HOLD. D is unchanged.
  - imem_ack=0 and stall=0: D_valid<=0 (bubble); D_PC and D_instr are unchanged. F_PC is unchanged.
  - imem_ack=0 and stall=1: nothing changes.
- HOLD: imem_req=0.
  - stall=1: stay in HOLD.
  - stall=0 ("transfer"): D_instr<=hold_buf, D_PC<=F_PC, D_valid<=1, F_PC<=next_pc, go to FETCH.
- next_pc selection, in priority order:
  - npc_sel=1 and stall=0 in the same cycle: npc_target.
  - else pend_v=1: pend_tgt.
  - else F_PC+4, modulo 2^32 (wraps silently).
- Redirect semantics (one delay slot): the instruction in F when npc_sel is sampled is the delay slot and always reaches D.
  - npc_sel=1 and stall=0 with no transfer that cycle: pend_v<=1, pend_tgt<=npc_target.
  - pend_v clears on the next transfer.
  - If npc_sel arrives while pend_v=1, the new target overwrites pend_tgt. A hazard unit that stalls correctly never produces this case.
- imem_rdata is latched only on a cycle where imem_ack=1 and imem_req=1.
- Latency: with imem_ack=1 every cycle and stall=0, one instruction enters D per cycle; D_PC lags F_PC by one cycle.
- Reset asserted mid-fetch: the outstanding request is abandoned. An imem_ack seen during reset, or in the first cycle after reset while imem_req was still 0, is ignored.

Optional Feature:
- Macro: FETCH_ADDR_CHK_EN.
- Defined:
  - Adds output D_exc_adel (1 bit, reset 0).
  - In FETCH, if F_PC[1:0]!=0 or F_PC is outside [PC_MIN, PC_MAX]: imem_req=0, and the cycle behaves as a transfer with D_instr<=0, D_exc_adel<=1, D_valid<=1. The stall rules are unchanged.
  - Any normal transfer writes D_exc_adel<=0.
- Undefined: the port is absent, no address check is made, and every F_PC is issued.

Test Plan:
1. Release reset, imem_ack=1 constant, stall=0 -> F_PC steps 0x3000, 0x3004, 0x3008 on successive edges; D_PC=0x3000 with D_valid=1 one edge after the first fetch.
2. Ack latency of 3 cycles -> imem_addr held at 0x3000 for 3 cycles, fetch_busy=1 for the first two, D_valid=0 bubbles, then D_PC=0x3000.
3. Branch at 0x3004 in D, npc_sel=1, npc_target=0x3100, imem_ack=1 -> D_PC sequence 0x3004, 0x3008 (delay slot), 0x3100.
4. Same as test 3 but the 0x3008 ack is delayed 2 cycles -> pend_v=1 meanwhile; after 0x3008 enters D, F_PC=0x3100 and pend_v=0.
5. stall=1 in the same cycle as imem_ack=1 with rdata 0x8C010000 -> HOLD, imem_req=0, D unchanged; drop stall -> D_instr=0x8C010000 next edge and F_PC advances by 4.
6. Assert reset during a pending fetch at 0x3010 -> all outputs return to reset values immediately; a stray imem_ack is ignored; fetch restarts at 0x3000.
